// File: rtl/bc_mac_wseq.sv
// Weight bit-plane sequencer for the bit-serial MAC array: double-buffers one
// vector of activations and weights, then presents one weight bit-plane per cycle, LSB first.
module bc_mac_wseq #(
   parameter int N     = 8,
   parameter int ABITS = 4,
   parameter int WBITS = 8,
   parameter int IW    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*ABITS-1:0]   in_act,
   input  logic [N*WBITS-1:0]   in_wgt,
   input  logic                 mac_stall,
   output logic                 mac_valid,
   output logic [N*ABITS-1:0]   mac_act,
   output logic [N-1:0]         mac_weight,
   output logic                 mac_sft_en,
   output logic                 mac_first,
   output logic                 mac_last,
   output logic [IW-1:0]        plane_idx,
   output logic                 busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [IW-1:0] LAST_PLANE = IW'(WBITS - 1);

   logic [0:0]           r_state;
   logic                 r_shadow_full;
   logic [N*ABITS-1:0]   r_shadow_act;
   logic [N*WBITS-1:0]   r_shadow_wgt;
   logic [N*WBITS-1:0]   r_active_wgt;

   logic                 r_mac_valid;
   logic [N*ABITS-1:0]   r_mac_act;
   logic [N-1:0]         r_mac_weight;
   logic                 r_mac_sft_en;
   logic                 r_mac_first;
   logic                 r_mac_last;
   logic [IW-1:0]        r_plane;

   logic                 w_run;
   logic                 w_accept;
   logic                 w_step;
   logic                 w_end;
   logic                 w_load_in;
   logic                 w_load_sh;
   logic                 w_load;
   logic                 w_to_shadow;
   logic                 w_shadow_full_nxt;
   logic [N*WBITS-1:0]   w_new_wgt;
   logic [N*ABITS-1:0]   w_new_act;
   logic [IW-1:0]        w_plane_inc;

   // Gather bit 'idx' of every lane's weight into one N-bit plane.
   function automatic logic [N-1:0] f_plane(input logic [N*WBITS-1:0] wgt,
                                            input logic [IW-1:0]      idx);
      logic [N-1:0] bits;
      bits = '0;
      for (int i = 0; i < N; i++) begin
         bits[i] = wgt[i*WBITS + int'(idx)];
      end
      return bits;
   endfunction

   assign w_run       = (r_state == ST_RUN);
   assign w_accept    = in_valid & ~r_shadow_full;
   assign w_step      = w_run & ~mac_stall;
   assign w_end       = w_step & (r_plane == LAST_PLANE);
   assign w_plane_inc = r_plane + IW'(1);

   // Active reload: straight from the input when idle, otherwise at the end of
   // the last plane, preferring the shadow over a freshly accepted vector.
   assign w_load_sh   = w_end & r_shadow_full;
   assign w_load_in   = w_accept & (~w_run | (w_end & ~r_shadow_full));
   assign w_load      = w_load_in | w_load_sh;
   assign w_to_shadow = w_accept & ~w_load_in;

   assign w_new_wgt = w_load_sh ? r_shadow_wgt : in_wgt;
   assign w_new_act = w_load_sh ? r_shadow_act : in_act;

   always_comb begin
      w_shadow_full_nxt = r_shadow_full | w_to_shadow;
      if (w_load_sh) begin
         w_shadow_full_nxt = w_to_shadow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_shadow_full <= 1'b0;
         r_mac_valid   <= 1'b0;
         r_mac_act     <= '0;
         r_mac_weight  <= '0;
         r_mac_sft_en  <= 1'b0;
         r_mac_first   <= 1'b0;
         r_mac_last    <= 1'b0;
         r_plane       <= '0;
      end else begin
         r_shadow_full <= w_shadow_full_nxt;
         if (w_load) begin
            r_state      <= ST_RUN;
            r_mac_valid  <= 1'b1;
            r_mac_act    <= w_new_act;
            r_mac_weight <= f_plane(w_new_wgt, '0);
            r_mac_sft_en <= 1'b0;
            r_mac_first  <= 1'b1;
            r_mac_last   <= 1'b0;
            r_plane      <= '0;
         end else if (w_end) begin
            r_state      <= ST_IDLE;
            r_mac_valid  <= 1'b0;
            r_mac_weight <= '0;
            r_mac_sft_en <= 1'b0;
            r_mac_first  <= 1'b0;
            r_mac_last   <= 1'b0;
            r_plane      <= '0;
         end else if (w_step) begin
            r_mac_weight <= f_plane(r_active_wgt, w_plane_inc);
            r_mac_sft_en <= 1'b1;
            r_mac_first  <= 1'b0;
            r_mac_last   <= (w_plane_inc == LAST_PLANE);
            r_plane      <= w_plane_inc;
         end
      end
   end

   // Vector storage carries no reset; the full flags qualify it.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_active_wgt <= w_new_wgt;
      end
      if (w_to_shadow) begin
         r_shadow_act <= in_act;
         r_shadow_wgt <= in_wgt;
      end
   end

   assign in_ready   = ~r_shadow_full;
   assign busy       = w_run | r_shadow_full;
   assign mac_valid  = r_mac_valid;
   assign mac_act    = r_mac_act;
   assign mac_weight = r_mac_weight;
   assign mac_sft_en = r_mac_sft_en;
   assign mac_first  = r_mac_first;
   assign mac_last   = r_mac_last;
   assign plane_idx  = r_plane;

endmodule
